// File: rtl/arb_mux_nxw.sv
// arb_mux_nxw: N-to-1 arbitrating multiplexer with a single registered output slot.
//
// Arbitration is either round-robin (mode = 0) or fixed priority, lowest index first (mode = 1).
// The winning channel's word is captured into the output register one cycle after transfer.
// A new word can replace the held word in the same cycle it is consumed, giving 1 word/cycle.
//
// Ports:
//   clk       rising-edge clock
//   reset_n   synchronous active-low reset
//   mode      0 = round-robin, 1 = fixed priority
//   in_data   per-channel data (unpacked, index = channel)
//   in_valid  per-channel request
//   in_ready  per-channel accept, one-hot or zero
//   out_data  registered selected data
//   out_valid out_data holds an unconsumed word
//   out_ready downstream accept
//   out_sel   registered index of the channel that supplied out_data
module arb_mux_nxw #(
    parameter int unsigned WIDTH  = 5,
    parameter int unsigned NUM_IN = 2,
    localparam int unsigned SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mode,
    input  logic [WIDTH-1:0]  in_data [NUM_IN],
    input  logic [NUM_IN-1:0] in_valid,
    output logic [NUM_IN-1:0] in_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SEL_W-1:0]  out_sel
);

    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              valid_q, valid_d;

    logic              slot_open;
    logic [NUM_IN-1:0] req_hi;     // requests at or above the round-robin pointer
    logic [NUM_IN-1:0] req_pick;   // request vector fed to the lowest-index picker
    logic [NUM_IN-1:0] found;      // a lower index already holds a request
    logic [NUM_IN-1:0] gnt;
    logic [SEL_W-1:0]  gnt_idx;
    logic              xfer_in;

    assign slot_open = !valid_q || out_ready;

    // Round-robin is a two-pass lowest-index search: first over requests at or above ptr,
    // falling back to all requests, which realises the wrap-around order. Fixed priority
    // skips the first pass.
    generate
        for (genvar i = 0; i < NUM_IN; i++) begin : g_hi
            assign req_hi[i] = in_valid[i] && (SEL_W'(i) >= ptr_q);
        end
    endgenerate

    assign req_pick = (!mode && (|req_hi)) ? req_hi : in_valid;

    generate
        for (genvar i = 0; i < NUM_IN; i++) begin : g_pick
            if (i == 0) begin : g_first
                assign found[i] = 1'b0;
            end else begin : g_rest
                assign found[i] = found[i-1] || req_pick[i-1];
            end
            assign gnt[i] = req_pick[i] && !found[i];
        end
    endgenerate

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (gnt[i]) begin
                gnt_idx = SEL_W'(i);
            end
        end
    end

    assign in_ready = gnt & {NUM_IN{slot_open && reset_n}};
    assign xfer_in  = |in_ready;

    always_comb begin
        ptr_d   = ptr_q;
        data_d  = data_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        if (xfer_in) begin
            data_d  = in_data[gnt_idx];
            sel_d   = gnt_idx;
            valid_d = 1'b1;
            ptr_d   = (32'(gnt_idx) == NUM_IN - 1) ? '0 : gnt_idx + SEL_W'(1);
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_q   <= '0;
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_sel   = sel_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_arb_mux_nxw.sv
// tb_arb_mux_nxw: directed scenarios plus randomized traffic for arb_mux_nxw (NUM_IN = 4,
// WIDTH = 5), checked every cycle against a behavioural model of the arbitration rules.
module tb_arb_mux_nxw;

    localparam int unsigned W = 5;
    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         mode;
    logic [W-1:0] in_data [N];
    logic [N-1:0] in_valid;
    logic [N-1:0] in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_sel;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit       m_valid;
    int       m_data;
    int       m_sel;
    int       m_ptr;

    arb_mux_nxw #(
        .WIDTH  (W),
        .NUM_IN (N)
    ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mode      (mode),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel   (out_sel)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, compare against the model, then advance the model at
    // the rising edge.
    task automatic step(input bit rst_n, input bit md, input logic [N-1:0] vld, input bit ordy);
        int  g;
        bit  open;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        reset_n   = rst_n;
        mode      = md;
        in_valid  = vld;
        out_ready = ordy;
        #1;
        open = !m_valid || ordy;
        g = -1;
        if (rst_n) begin
            if (md) begin
                for (int i = N - 1; i >= 0; i--) if (vld[i]) g = i;
            end else begin
                for (int k = N - 1; k >= 0; k--) if (vld[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        exp_rdy = (g >= 0 && open) ? N'(1 << g) : '0;
        check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
        check_eq("out_valid", 32'(out_valid), 32'(m_valid));
        check_eq("out_data", 32'(out_data), m_data);
        check_eq("out_sel", 32'(out_sel), m_sel);
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 0;
            m_data  = 0;
            m_sel   = 0;
            m_ptr   = 0;
        end else if (g >= 0 && open) begin
            m_valid = 1;
            m_data  = int'(in_data[g]);
            m_sel   = g;
            m_ptr   = (g + 1) % N;
        end else if (ordy) begin
            m_valid = 0;
        end
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        mode      = 1'b0;
        in_valid  = '0;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) in_data[i] = W'(i + 8);
        // Model starts unknown-free only after reset; mirror the reset values.
        m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 0;

        // Reset held two cycles with every channel requesting.
        step(1'b0, 1'b0, 4'b1111, 1'b1);
        step(1'b0, 1'b0, 4'b1111, 1'b1);
        check_eq("rst_in_ready", 32'(in_ready), 32'h0);
        check_eq("rst_out_valid", 32'(out_valid), 32'h0);
        check_eq("rst_out_data", 32'(out_data), 32'h0);
        check_eq("rst_out_sel", 32'(out_sel), 32'h0);

        // Round-robin fairness: 0,1,2,3,0 one word per cycle.
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, 4'b1111, 1'b1);
            check_eq("rr_sel", 32'(out_sel), 32'(k % 4));
            check_eq("rr_data", 32'(out_data), 32'(8 + k % 4));
            check_eq("rr_valid", 32'(out_valid), 32'h1);
        end

        // Fixed priority: channel 1 beats channel 3 until it drops.
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 4'b1010, 1'b1);
            check_eq("fp_sel", 32'(out_sel), 32'h1);
            check_eq("fp_ready", 32'(in_ready), 32'h2);
        end
        step(1'b1, 1'b1, 4'b1000, 1'b1);
        check_eq("fp_drop_sel", 32'(out_sel), 32'h3);

        // Backpressure: word 21 from channel 2 held for three cycles.
        in_data[2] = W'(21);
        step(1'b1, 1'b1, 4'b0100, 1'b1);
        check_eq("bp_load", 32'(out_data), 32'd21);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 4'b1111, 1'b0);
            check_eq("bp_data", 32'(out_data), 32'd21);
            check_eq("bp_sel", 32'(out_sel), 32'h2);
            check_eq("bp_ready", 32'(in_ready), 32'h0);
        end
        step(1'b1, 1'b0, 4'b1111, 1'b1);
        check_eq("bp_release_sel", 32'(out_sel), 32'h3);

        // Wrap and skip: ptr = 3 with requests on 0 and 2.
        step(1'b1, 1'b1, 4'b0100, 1'b1);
        step(1'b1, 1'b0, 4'b0101, 1'b1);
        check_eq("wrap_sel", 32'(out_sel), 32'h0);
        step(1'b1, 1'b0, 4'b0101, 1'b1);
        check_eq("skip_sel", 32'(out_sel), 32'h2);

        // Reset pulse while a word is held and backpressured.
        step(1'b1, 1'b0, 4'b0000, 1'b0);
        step(1'b0, 1'b0, 4'b0000, 1'b0);
        check_eq("midrst_valid", 32'(out_valid), 32'h0);
        step(1'b1, 1'b0, 4'b1000, 1'b0);
        check_eq("midrst_sel", 32'(out_sel), 32'h3);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) in_data[i] = W'($urandom);
            step(($urandom_range(0, 29) != 0), 1'($urandom), N'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/arb_mux_nxw.md
ARB_MUX_NXW -- requirements
Module: arb_mux_nxw

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, meaning bits per data channel (>=1).
REQ-002 The block SHALL have parameter NUM_IN, default 2, meaning number of input channels (>=2, power of two not required).
REQ-003 The block SHALL define SEL_W = max(1, clog2(NUM_IN)) as a derived width, not overridable.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-005 reset_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-006 mode  input  1  0 = round-robin arbitration, 1 = fixed priority (lowest index wins).
REQ-007 in_data  input  WIDTH x NUM_IN (unpacked array, index = channel)  per-channel data.
REQ-008 in_valid  input  NUM_IN  per-channel request.
REQ-009 in_ready  output  NUM_IN  per-channel accept, one-hot or zero.
REQ-010 out_data  output  WIDTH  registered selected data.
REQ-011 out_valid  output  1  out_data holds an unconsumed word.
REQ-012 out_ready  input  1  downstream accept.
REQ-013 out_sel  output  SEL_W  registered index of the channel that supplied out_data.

Function
REQ-014 Transfer on a channel SHALL occur when in_valid[i] && in_ready[i] at a rising clk; transfer at output when out_valid && out_ready.
REQ-015 The slot SHALL be "open" when !out_valid || out_ready (combinational).
REQ-016 in_ready[i] SHALL be 1 only for the granted channel and only while the slot is open and reset_n = 1.
REQ-017 Grant, mode 1: lowest index i with in_valid[i] = 1.
REQ-018 Grant, mode 0: first i with in_valid[i] = 1 searching ptr, ptr+1, ..., NUM_IN-1, 0, ..., ptr-1 (wrap-around).
REQ-019 ptr SHALL update to (g+1) mod NUM_IN after every input transfer from channel g, in both modes; ptr = NUM_IN-1 wraps to 0.
REQ-020 On input transfer, out_data <= in_data[g], out_sel <= g, out_valid <= 1, next cycle (latency 1 cycle).
REQ-021 Simultaneous output and input transfer in one cycle SHALL replace the word with no bubble (throughput 1 word/cycle).
REQ-022 Output transfer with no input transfer SHALL clear out_valid; out_data and out_sel SHALL hold last values.
REQ-023 While out_valid && !out_ready, out_data, out_sel, out_valid and ptr SHALL stay stable and all in_ready SHALL be 0.
REQ-024 No valid inputs: no grant, in_ready = 0, ptr unchanged.
REQ-025 mode changes SHALL take effect on the same cycle's grant; ptr is not reset by a mode change.
REQ-026 in_valid deassertion without transfer is legal; the block SHALL not record un-transferred requests.
REQ-027 Grant logic SHALL be built from a parametrised generate structure, no fixed NUM_IN case tables.

Reset
REQ-028 When reset_n = 0 at a rising clk: out_valid <= 0, out_data <= 0, out_sel <= 0, ptr <= 0.
REQ-029 While reset_n = 0, in_ready SHALL be all 0 combinationally.
REQ-030 Reset mid-operation SHALL discard any held word; out_valid is 0 the cycle after reset asserts, regardless of out_ready.
REQ-031 First grant after reset in mode 0 SHALL start the search at channel 0.

Verification (NUM_IN = 4, WIDTH = 5)
REQ-032 Reset: reset_n = 0 two cycles with all in_valid = 1 -> in_ready = 0000, out_valid = 0, out_data = 0, out_sel = 0.
REQ-033 Round-robin fairness: mode 0, in_valid = 1111, data ch_i = i+8, out_ready = 1 constantly -> out_sel sequence 0,1,2,3,0 with out_data 8,9,10,11,8, one word per cycle.
REQ-034 Fixed priority: mode 1, in_valid = 1010, out_ready = 1 -> every cycle in_ready = 0010, out_sel = 1; drop in_valid[1] -> out_sel = 3 next.
REQ-035 Backpressure: word from ch2 (value 21) held, out_ready = 0 for 3 cycles with in_valid = 1111 -> out_data = 21, out_sel = 2, in_ready = 0000 all 3 cycles; on release, ch3 granted same cycle.
REQ-036 Wrap/skip: mode 0, ptr = 3, in_valid = 0101 -> grant ch0, then ptr = 1 -> grant ch2.
REQ-037 Reset mid-hold: out_valid = 1, out_ready = 0, reset_n pulsed low one cycle -> out_valid = 0, ptr = 0 next cycle; with in_valid = 1000 afterwards, ch3 granted.
